// File: rtl/qpmm_canon_reduce_pkg.sv
// Curve constants and shared types for the QPMM canonical-reduction stage.
// Defaults describe the P-256 field; the Z width leaves headroom for the redundant QPMM result.
package qpmm_canon_reduce_pkg;

    localparam int LEN_P      = 256;
    localparam int LEN_QPMM_Z = 258;

    typedef logic [LEN_P-1:0] uint_p_t;

    localparam uint_p_t P_MOD =
        256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/qpmm_canon_reduce_if.sv
// Valid/ready bundle between the QPMM multiplier, the reducer and its consumer.
// master drives the input word and out_ready; slave is the reducer side.
interface qpmm_canon_reduce_if
    import qpmm_canon_reduce_pkg::*;
#(
    parameter int ZW = LEN_QPMM_Z,
    parameter int PW = LEN_P
);
    logic          in_valid;
    logic          in_ready;
    logic [ZW-1:0] in_z;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_z;

    modport master (
        output in_valid, in_z, out_ready,
        input  in_ready, out_valid, out_z
    );

    modport slave (
        input  in_valid, in_z, out_ready,
        output in_ready, out_valid, out_z
    );
endinterface

// File: rtl/qpmm_canon_reduce_limb_sub.sv
// One limb of a - b - bin with borrow out; purely combinational.
// The parent registers the borrow between limbs.
module qpmm_limb_sub #(
    parameter int W = 64
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         bin_i,
    output logic [W-1:0] diff_o,
    output logic         bout_o
);
    logic [W:0] full;

    assign full   = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, bin_i};
    assign diff_o = full[W-1:0];
    assign bout_o = full[W];
endmodule

// File: rtl/qpmm_canon_reduce.sv
// Limb-serial reduction of a redundant QPMM result Z to Z mod MOD via up to NSUB subtractions.
// Latency k*NL+1 cycles (k passes); single outstanding item, in_ready only in IDLE, output held until out_ready.
module qpmm_canon_reduce
    import qpmm_canon_reduce_pkg::*;
#(
    parameter int            ZW   = LEN_QPMM_Z,
    parameter int            PW   = LEN_P,
    parameter logic [ZW-1:0] MOD  = ZW'(P_MOD),
    parameter int            LIMB = 64,
    parameter int            NSUB = 3
) (
    input logic                clk,
    input logic                rstn,
    qpmm_canon_reduce_if.slave bus
);
    localparam int NL  = (ZW + LIMB - 1) / LIMB;
    localparam int AW  = NL * LIMB;
    localparam int LCW = (NL > 1) ? $clog2(NL) : 1;
    localparam int PCW = $clog2(NSUB + 1);
    localparam logic [AW-1:0] MOD_EXT = AW'(MOD);
    localparam logic [ZW+7:0] Z_LIMIT = (ZW+8)'(NSUB + 1) * (ZW+8)'(MOD);

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [AW-1:0]   r_q, r_d;
    logic [LCW-1:0]  limb_q, limb_d;
    logic [PCW-1:0]  pass_q, pass_d;
    logic            borrow_q, borrow_d;
    logic [LIMB-1:0] a_limb, m_limb, diff;
    logic            bout;
    logic            last_limb;
    logic [AW-1:0]   r_full;

    assign a_limb    = acc_q[limb_q*LIMB +: LIMB];
    assign m_limb    = MOD_EXT[limb_q*LIMB +: LIMB];
    assign last_limb = (limb_q == LCW'(NL - 1));

    qpmm_limb_sub #(.W(LIMB)) u_limb_sub (
        .a_i   (a_limb),
        .b_i   (m_limb),
        .bin_i (borrow_q),
        .diff_o(diff),
        .bout_o(bout)
    );

    assign bus.in_ready  = (state_q == ST_IDLE) && rstn;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_z     = (state_q == ST_DONE) ? acc_q[PW-1:0] : '0;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        r_d      = r_q;
        limb_d   = limb_q;
        pass_d   = pass_q;
        borrow_d = borrow_q;
        // Trial difference including the limb being produced this cycle.
        r_full   = r_q;
        r_full[limb_q*LIMB +: LIMB] = diff;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    acc_d    = AW'(bus.in_z);
                    limb_d   = '0;
                    pass_d   = PCW'(1);
                    borrow_d = 1'b0;
                    state_d  = ST_SUB;
                end
            end
            ST_SUB: begin
                r_d      = r_full;
                borrow_d = bout;
                limb_d   = limb_q + LCW'(1);
                if (last_limb) begin
                    limb_d   = '0;
                    borrow_d = 1'b0;
                    if (bout) begin
                        state_d = ST_DONE;
                    end else begin
                        acc_d = r_full;
                        if (pass_q == PCW'(NSUB)) begin
                            state_d = ST_DONE;
                        end else begin
                            pass_d = pass_q + PCW'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            r_q      <= '0;
            limb_q   <= '0;
            pass_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            r_q      <= r_d;
            limb_q   <= limb_d;
            pass_q   <= pass_d;
            borrow_q <= borrow_d;
        end
    end

    a_legal_input: assert property (@(posedge clk) disable iff (!rstn)
        (bus.in_valid && bus.in_ready) |-> ({8'd0, bus.in_z} < Z_LIMIT));

endmodule

// File: tb/tb_qpmm_canon_reduce.sv
// Bench for qpmm_canon_reduce at ZW=10, PW=8, MOD=251, LIMB=4, NSUB=3.
module tb_qpmm_canon_reduce;
    localparam int ZW   = 10;
    localparam int PW   = 8;
    localparam int LIMB = 4;
    localparam int NSUB = 3;
    localparam int NL   = 3;
    localparam int MODV = 251;
    localparam int ZMAX = (NSUB + 1) * MODV - 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    qpmm_canon_reduce_if #(.ZW(ZW), .PW(PW)) bus ();

    qpmm_canon_reduce #(
        .ZW  (ZW),
        .PW  (PW),
        .MOD (10'd251),
        .LIMB(LIMB),
        .NSUB(NSUB)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int model_res(input int z);
        return z % MODV;
    endfunction

    function automatic int model_lat(input int z);
        int k;
        k = z / MODV + 1;
        if (k > NSUB) k = NSUB;
        return k * NL + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int z, output int ok);
        int n;
        bus.in_valid = 1'b1;
        bus.in_z     = ZW'(z);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        ok = int'(bus.in_ready);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        int n;
        n = 0;
        while (!bus.out_valid && n < 60) begin
            step();
            n++;
        end
        lat = bus.out_valid ? n + 1 : -1;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_z      = '0;
        bus.out_ready = 1'b0;
        rstn          = 1'b0;
        #2;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", bus.out_valid); end
        checks++; if (bus.out_z !== 8'd0) begin errors++; $display("FAIL rst_out_z got %0d exp 0", bus.out_z); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b exp 0", bus.in_ready); end
        step();
        step();
        rstn = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %0b exp 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        int ok, lat;
        bus.out_ready = 1'b1;
        accept(100, ok);
        checks++; if (ok != 1) begin errors++; $display("FAIL basic_accept got %0d exp 1", ok); end
        wait_out(lat);
        checks++; if (bus.out_z !== 8'd100) begin errors++; $display("FAIL basic_z got %0d exp 100", bus.out_z); end
        checks++; if (lat != 4) begin errors++; $display("FAIL basic_lat got %0d exp 4", lat); end
        step();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %0b exp 1", bus.in_ready); end
    endtask

    task automatic test_boundaries();
        int zs[5]   = '{251, 502, 1003, 0, 250};
        int res[5]  = '{0, 0, 250, 0, 250};
        int lats[5] = '{7, 10, 10, 4, 4};
        int ok, lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            accept(zs[i], ok);
            wait_out(lat);
            checks++;
            if (bus.out_z !== PW'(res[i])) begin
                errors++; $display("FAIL bnd_z in=%0d got %0d exp %0d", zs[i], bus.out_z, res[i]);
            end
            checks++;
            if (lat != lats[i]) begin
                errors++; $display("FAIL bnd_lat in=%0d got %0d exp %0d", zs[i], lat, lats[i]);
            end
            step();
        end
    endtask

    task automatic test_hold();
        int ok, lat;
        bus.out_ready = 1'b0;
        accept(300, ok);
        wait_out(lat);
        checks++; if (lat != 7) begin errors++; $display("FAIL hold_lat got %0d exp 7", lat); end
        bus.in_valid = 1'b1;
        bus.in_z     = 10'd7;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_z !== 8'd49 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cyc=%0d got v=%0b z=%0d rdy=%0b exp v=1 z=49 rdy=0",
                         i, bus.out_valid, bus.out_z, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release got v=%0b rdy=%0b exp v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int ok, lat;
        bus.out_ready = 1'b1;
        accept(700, ok);
        repeat (4) step();
        rstn = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.out_valid !== 1'b0 || bus.out_z !== 8'd0 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL midrst_outputs cyc=%0d got v=%0b z=%0d rdy=%0b exp 0 0 0",
                         i, bus.out_valid, bus.out_z, bus.in_ready);
            end
            step();
        end
        rstn = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_idle got rdy=%0b v=%0b exp rdy=1 v=0", bus.in_ready, bus.out_valid);
        end
        accept(5, ok);
        wait_out(lat);
        checks++; if (bus.out_z !== 8'd5) begin errors++; $display("FAIL midrst_z got %0d exp 5", bus.out_z); end
        checks++; if (lat != 4) begin errors++; $display("FAIL midrst_lat got %0d exp 4", lat); end
        step();
    endtask

    task automatic test_back_to_back();
        int specials[6] = '{0, 250, 251, 502, 753, ZMAX};
        int z, nz, n, busy_rdy;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        z = int'($urandom_range(0, ZMAX));
        bus.in_z = ZW'(z);
        for (int v = 0; v < 2000; v++) begin
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready v=%0d got %0b exp 1", v, bus.in_ready);
            end
            step();
            if (v % 8 == 0) nz = specials[$urandom_range(0, 5)];
            else            nz = int'($urandom_range(0, ZMAX));
            bus.in_z = ZW'(nz);
            n = 0;
            busy_rdy = 0;
            while (!bus.out_valid && n < 60) begin
                if (bus.in_ready !== 1'b0) busy_rdy++;
                step();
                n++;
            end
            if (bus.in_ready !== 1'b0) busy_rdy++;
            checks++;
            if (busy_rdy != 0) begin
                errors++; $display("FAIL b2b_busy_ready v=%0d got %0d cycles exp 0", v, busy_rdy);
            end
            checks++;
            if (bus.out_z !== PW'(model_res(z))) begin
                errors++; $display("FAIL b2b_z v=%0d in=%0d got %0d exp %0d", v, z, bus.out_z, model_res(z));
            end
            checks++;
            if ((bus.out_valid ? n + 1 : -1) != model_lat(z)) begin
                errors++; $display("FAIL b2b_lat v=%0d in=%0d got %0d exp %0d", v, z, n + 1, model_lat(z));
            end
            step();
            z = nz;
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
